// File: rtl/ex_hazard_if.sv
`default_nettype none
// ============================================================================
// Module     : ex_hazard_if
// Description: Pipeline-side signals seen by the EX-stage hazard controller.
// Revision   : 1.0 - initial release
// ============================================================================
interface ex_hazard_if #(
    parameter int REG_WIDTH = 4
);
    logic [REG_WIDTH-1:0] rs1D_i;
    logic [REG_WIDTH-1:0] rs2D_i;
    logic                 use_rs1D_i;
    logic                 use_rs2D_i;
    logic [REG_WIDTH-1:0] rs1E_i;
    logic [REG_WIDTH-1:0] rs2E_i;
    logic [REG_WIDTH-1:0] WriteRegE_i;
    logic                 RegWriteE_i;
    logic                 MemReadE_i;
    logic                 FloatingE_i;
    logic [REG_WIDTH-1:0] WriteRegM_i;
    logic                 RegWriteM_i;
    logic                 BranchM_i;
    logic                 branch_taken_i;
    logic [REG_WIDTH-1:0] WriteRegW_i;
    logic                 RegWriteW_i;
    logic [1:0]           alu_src1_o;
    logic [1:0]           alu_src2_o;
    logic                 stall_pc_o;
    logic                 stall_IF_ID_o;
    logic                 stall_ID_EX_o;
    logic                 flush_IF_ID_o;
    logic                 flush_ID_EX_o;
    logic                 flush_EX_MEM_o;
    logic                 fp_busy_o;

    modport master (
        output rs1D_i, rs2D_i, use_rs1D_i, use_rs2D_i, rs1E_i, rs2E_i,
               WriteRegE_i, RegWriteE_i, MemReadE_i, FloatingE_i,
               WriteRegM_i, RegWriteM_i, BranchM_i, branch_taken_i,
               WriteRegW_i, RegWriteW_i,
        input  alu_src1_o, alu_src2_o, stall_pc_o, stall_IF_ID_o,
               stall_ID_EX_o, flush_IF_ID_o, flush_ID_EX_o, flush_EX_MEM_o,
               fp_busy_o
    );

    modport slave (
        input  rs1D_i, rs2D_i, use_rs1D_i, use_rs2D_i, rs1E_i, rs2E_i,
               WriteRegE_i, RegWriteE_i, MemReadE_i, FloatingE_i,
               WriteRegM_i, RegWriteM_i, BranchM_i, branch_taken_i,
               WriteRegW_i, RegWriteW_i,
        output alu_src1_o, alu_src2_o, stall_pc_o, stall_IF_ID_o,
               stall_ID_EX_o, flush_IF_ID_o, flush_ID_EX_o, flush_EX_MEM_o,
               fp_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : ex_hazard_ctrl
// Description: EX-stage forwarding selects, stall/flush control and
//              multi-cycle FP sequencing (IDLE/BUSY/DONE + down-counter).
// Revision   : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl #(
    parameter int REG_WIDTH = 4,
    parameter int FP_STALL  = 3,
    parameter int CNT_WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ex_hazard_if.slave    hz
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam bit                   FP_EN    = (FP_STALL != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = FP_EN ? CNT_WIDTH'(FP_STALL - 1) : '0;
    localparam state_t               FP_START = (FP_STALL == 1) ? ST_DONE : ST_BUSY;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    logic [REG_WIDTH-1:0] rs1d, rs2d, rs1e, rs2e, wr_e, wr_m, wr_w;
    logic                 br, fp_stall, lu;

    assign rs1d = hz.rs1D_i;
    assign rs2d = hz.rs2D_i;
    assign rs1e = hz.rs1E_i;
    assign rs2e = hz.rs2E_i;
    assign wr_e = hz.WriteRegE_i;
    assign wr_m = hz.WriteRegM_i;
    assign wr_w = hz.WriteRegW_i;

    assign br       = hz.BranchM_i & hz.branch_taken_i;
    assign fp_stall = !br & (((state == ST_IDLE) & hz.FloatingE_i & FP_EN) |
                             (state == ST_BUSY));
    assign lu       = !br & !fp_stall & hz.MemReadE_i & hz.RegWriteE_i &
                      ((hz.use_rs1D_i & (rs1d == wr_e)) |
                       (hz.use_rs2D_i & (rs2d == wr_e)));

    always_comb begin
        hz.alu_src1_o     = 2'd0;
        hz.alu_src2_o     = 2'd0;
        hz.stall_pc_o     = 1'b0;
        hz.stall_IF_ID_o  = 1'b0;
        hz.stall_ID_EX_o  = 1'b0;
        hz.flush_IF_ID_o  = 1'b0;
        hz.flush_ID_EX_o  = 1'b0;
        hz.flush_EX_MEM_o = 1'b0;
        hz.fp_busy_o      = 1'b0;
        if (!rst) begin
            // MEM result is younger than WB, so it wins when both match
            if (hz.RegWriteM_i && (wr_m == rs1e))      hz.alu_src1_o = 2'd1;
            else if (hz.RegWriteW_i && (wr_w == rs1e)) hz.alu_src1_o = 2'd2;
            if (hz.RegWriteM_i && (wr_m == rs2e))      hz.alu_src2_o = 2'd1;
            else if (hz.RegWriteW_i && (wr_w == rs2e)) hz.alu_src2_o = 2'd2;

            hz.fp_busy_o = (state == ST_BUSY);

            if (br) begin
                hz.flush_IF_ID_o  = 1'b1;
                hz.flush_ID_EX_o  = 1'b1;
                hz.flush_EX_MEM_o = 1'b1;
            end else if (fp_stall) begin
                hz.stall_pc_o     = 1'b1;
                hz.stall_IF_ID_o  = 1'b1;
                hz.stall_ID_EX_o  = 1'b1;
                hz.flush_EX_MEM_o = 1'b1;
            end else if (lu) begin
                hz.stall_pc_o     = 1'b1;
                hz.stall_IF_ID_o  = 1'b1;
                hz.flush_ID_EX_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!br && hz.FloatingE_i && FP_EN) begin
                        cnt   <= CNT_LOAD;
                        state <= FP_START;
                    end
                end
                ST_BUSY: begin
                    // An older taken branch squashes the FP op still in EX
                    if (br) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_ex_hazard_ctrl
// Description: Directed and randomized checks of ex_hazard_ctrl against a
//              cycle-level behavioural model of the hazard rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_ctrl;
    localparam int REG_WIDTH = 4;
    localparam int FP_STALL  = 3;
    localparam int CNT_WIDTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    // Model of the FP op in EX: whether one is present and how many stall
    // cycles it has already been granted.
    bit m_in_op;
    int m_served;

    ex_hazard_if #(.REG_WIDTH(REG_WIDTH)) hif ();

    ex_hazard_ctrl #(
        .REG_WIDTH(REG_WIDTH),
        .FP_STALL (FP_STALL),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] fsel(input logic [REG_WIDTH-1:0] rs);
        if (hif.RegWriteM_i && hif.WriteRegM_i == rs) return 2'd1;
        if (hif.RegWriteW_i && hif.WriteRegW_i == rs) return 2'd2;
        return 2'd0;
    endfunction

    // {src1, src2, stall_pc, stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM, fp_busy}
    function automatic logic [10:0] model_exp();
        logic       br, busy, fp, lu;
        logic [5:0] sf;
        if (rst) return '0;
        br   = hif.BranchM_i && hif.branch_taken_i;
        busy = m_in_op && (m_served < FP_STALL);
        fp   = !br && ((!m_in_op && hif.FloatingE_i && FP_STALL > 0) || busy);
        lu   = !br && !fp && hif.MemReadE_i && hif.RegWriteE_i &&
               ((hif.use_rs1D_i && hif.rs1D_i == hif.WriteRegE_i) ||
                (hif.use_rs2D_i && hif.rs2D_i == hif.WriteRegE_i));
        if (br)      sf = 6'b000111;
        else if (fp) sf = 6'b111001;
        else if (lu) sf = 6'b110010;
        else         sf = 6'b000000;
        return {fsel(hif.rs1E_i), fsel(hif.rs2E_i), sf, busy};
    endfunction

    function automatic logic [10:0] actual();
        return {hif.alu_src1_o, hif.alu_src2_o, hif.stall_pc_o, hif.stall_IF_ID_o,
                hif.stall_ID_EX_o, hif.flush_IF_ID_o, hif.flush_ID_EX_o,
                hif.flush_EX_MEM_o, hif.fp_busy_o};
    endfunction

    task automatic model_update();
        bit br;
        br = hif.BranchM_i && hif.branch_taken_i;
        if (rst) begin
            m_in_op  = 1'b0;
            m_served = 0;
        end else if (!m_in_op) begin
            if (!br && hif.FloatingE_i && FP_STALL > 0) begin
                m_in_op  = 1'b1;
                m_served = 1;
            end
        end else if (m_served >= FP_STALL || br) begin
            m_in_op  = 1'b0;
            m_served = 0;
        end else begin
            m_served++;
        end
    endtask

    // Called with inputs stable for the current cycle; moves to just after the next edge.
    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        hif.rs1D_i = '0; hif.rs2D_i = '0; hif.use_rs1D_i = 0; hif.use_rs2D_i = 0;
        hif.rs1E_i = '0; hif.rs2E_i = '0; hif.WriteRegE_i = '0;
        hif.RegWriteE_i = 0; hif.MemReadE_i = 0; hif.FloatingE_i = 0;
        hif.WriteRegM_i = '0; hif.RegWriteM_i = 0; hif.BranchM_i = 0;
        hif.branch_taken_i = 0; hif.WriteRegW_i = '0; hif.RegWriteW_i = 0;
    endtask

    task automatic rand_inputs();
        hif.rs1D_i = 4'($urandom_range(0, 3)); hif.rs2D_i = 4'($urandom_range(0, 3));
        hif.use_rs1D_i = 1'($urandom); hif.use_rs2D_i = 1'($urandom);
        hif.rs1E_i = 4'($urandom_range(0, 3)); hif.rs2E_i = 4'($urandom_range(0, 3));
        hif.WriteRegE_i = 4'($urandom_range(0, 3));
        hif.RegWriteE_i = 1'($urandom); hif.MemReadE_i = 1'($urandom);
        hif.FloatingE_i = ($urandom_range(0, 5) == 0);
        hif.WriteRegM_i = 4'($urandom_range(0, 3)); hif.RegWriteM_i = 1'($urandom);
        hif.BranchM_i = 1'($urandom); hif.branch_taken_i = ($urandom_range(0, 3) == 0);
        hif.WriteRegW_i = 4'($urandom_range(0, 3)); hif.RegWriteW_i = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            hif.FloatingE_i = 1'b1;
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp || actual() !== 11'd0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %b expected %b", cyc, actual(), exp);
            end
            advance();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        logic [10:0] exp;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    hif.RegWriteM_i = 1; hif.WriteRegM_i = 4'd3;
                    hif.RegWriteW_i = 1; hif.WriteRegW_i = 4'd3;
                    hif.rs1E_i = 4'd3; hif.rs2E_i = 4'd3;
                end
                1: begin
                    hif.RegWriteW_i = 1; hif.WriteRegW_i = 4'd5;
                    hif.rs1E_i = 4'd1; hif.rs2E_i = 4'd5;
                end
                default: begin
                    hif.RegWriteW_i = 0; hif.WriteRegW_i = 4'd5;
                    hif.rs1E_i = 4'd1; hif.rs2E_i = 4'd5;
                end
            endcase
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL forwarding case%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        logic [10:0] exp;
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            hif.MemReadE_i = 1; hif.RegWriteE_i = 1; hif.WriteRegE_i = 4'd2;
            hif.rs1D_i = 4'd2; hif.use_rs1D_i = (i == 0);
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL load_use case%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
    endtask

    task automatic test_fp_seq();
        logic [10:0] exp;
        int stalls, busies;
        stalls = 0; busies = 0;
        clear_inputs();
        for (int i = 0; i < FP_STALL + 2; i++) begin
            hif.FloatingE_i = (i <= FP_STALL);
            exp = model_exp();
            @(negedge clk);
            stalls += int'(hif.stall_pc_o);
            busies += int'(hif.fp_busy_o);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL fp_seq cyc%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
        n_cmp++;
        if (stalls !== FP_STALL || busies !== FP_STALL - 1) begin
            n_bad++;
            $display("FAIL fp_counts: got stalls=%0d busy=%0d expected stalls=%0d busy=%0d",
                     stalls, busies, FP_STALL, FP_STALL - 1);
        end
        clear_inputs();
    endtask

    task automatic test_branch_fp();
        logic [10:0] exp;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            hif.FloatingE_i    = (i < 2);
            hif.BranchM_i      = (i == 1);
            hif.branch_taken_i = (i == 1);
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL branch_fp cyc%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_rst_busy();
        logic [10:0] exp;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            hif.FloatingE_i = (i < 2);
            rst = (i == 1);
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL rst_busy cyc%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        clear_inputs();
        for (int i = 0; i < 2 * (FP_STALL + 1) + 1; i++) begin
            hif.FloatingE_i = (i < 2 * (FP_STALL + 1));
            hif.MemReadE_i = 1; hif.RegWriteE_i = 1; hif.WriteRegE_i = 4'd7;
            hif.rs2D_i = 4'd7; hif.use_rs2D_i = 1;
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [10:0] exp;
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 59) == 0);
            exp = model_exp();
            @(negedge clk);
            n_cmp++;
            if (actual() !== exp) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %b expected %b", i, actual(), exp);
            end
            advance();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_in_op = 1'b0; m_served = 0;
        rst = 1'b1;
        clear_inputs();
        advance();
        test_reset();
        test_forwarding();
        test_load_use();
        test_fp_seq();
        test_branch_fp();
        test_rst_busy();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
